// File: rtl/spi_dac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_dac_pkg
// Description : Shared constants and FSM state type for the SPI DAC-side
//               receiver. Frame field positions describe the 16-bit link word:
//               [15] channel (0=A, 1=B), [14] gain, [13:12] ignored,
//               [11:0] DAC code.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_dac_pkg;

    localparam int FRAME_W  = 16;
    localparam int CH_BIT   = 15;
    localparam int GAIN_BIT = 14;
    localparam int CODE_MSB = 11;
    localparam int CODE_W   = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_dac_rx_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : STAGES-deep synchronizer for one asynchronous link pin,
//               followed by a registered edge detector.
// Ports       : clk, rst_n  - system clock, async active-low reset
//               d           - asynchronous input pin
//               level       - synchronized level, delayed one extra cycle so
//                             it lines up with the rise/fall pulses
//               rise, fall  - one-cycle registered edge pulses
// Parameters  : STAGES  - synchronizer depth (>= 2)
//               RST_VAL - reset value of the chain; set to the pin's idle
//                         level so reset release creates no false edge
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q, chain_d;
    logic              prev_q, prev_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
        prev_d  = chain_q[STAGES-1];
        rise_d  = chain_q[STAGES-1] & ~prev_q;
        fall_d  = ~chain_q[STAGES-1] & prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = prev_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/spi_dac_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_dac_rx
// Description : SPI DAC-side receiver. Oversamples sclk/din/sync/ldac/clr on
//               clk, deserializes MSB-first frames on sclk falling edges,
//               commits them to the input register on sync rising edge and
//               transfers code+gain into the addressed DAC register on an
//               ldac falling edge. clr (low level) clears the DAC registers.
// Ports       : clk, rst_n            - system clock, async active-low reset
//               sclk,din,sync,ldac,clr - asynchronous link pins
//               frame_data  [N]       - last committed frame
//               frame_valid           - pulse on frame commit
//               frame_err             - pulse on rejected frame length
//               busy                  - high while shifting a frame
//               dac_a/dac_b [12]      - DAC registers
//               gain_a/gain_b         - gain bits latched with each register
// Config      : SPI_DAC_RX_FRAME_CHECK_EN - when defined, any frame whose bit
//               count differs from N is rejected with frame_err. Otherwise
//               frame_err is 0, short frames are dropped silently and long
//               frames commit their last N bits.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_dac_rx
    import spi_dac_pkg::*;
#(
    parameter int N           = FRAME_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              din,
    input  logic              sync,
    input  logic              ldac,
    input  logic              clr,
    output logic [N-1:0]      frame_data,
    output logic              frame_valid,
    output logic              frame_err,
    output logic              busy,
    output logic [CODE_W-1:0] dac_a,
    output logic [CODE_W-1:0] dac_b,
    output logic              gain_a,
    output logic              gain_b
);

    localparam logic [4:0] C_FRAME_LEN = 5'(N);
    localparam logic [4:0] C_CNT_MAX   = 5'd31;

    // ------------------------------------------------------------------
    // Link synchronizers. sync/ldac/clr idle high, so their chains reset
    // high to avoid a false frame start or transfer after reset release.
    // ------------------------------------------------------------------
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic din_lvl,  din_rise,  din_fall;
    logic sync_lvl, sync_rise, sync_fall;
    logic ldac_lvl, ldac_rise, ldac_fall;
    logic clr_lvl,  clr_rise,  clr_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
        .clk(clk), .rst_n(rst_n), .d(din),
        .level(din_lvl), .rise(din_rise), .fall(din_fall));

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sync (
        .clk(clk), .rst_n(rst_n), .d(sync),
        .level(sync_lvl), .rise(sync_rise), .fall(sync_fall));

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ldac (
        .clk(clk), .rst_n(rst_n), .d(ldac),
        .level(ldac_lvl), .rise(ldac_rise), .fall(ldac_fall));

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clr (
        .clk(clk), .rst_n(rst_n), .d(clr),
        .level(clr_lvl), .rise(clr_rise), .fall(clr_fall));

    // Only a subset of the synchronizer outputs drives logic.
    logic w_unused;
    assign w_unused = &{1'b0, sclk_lvl, sclk_rise, din_rise, din_fall,
                        sync_fall, ldac_lvl, ldac_rise, clr_rise, clr_fall};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q,     state_d;
    logic [N-1:0]      shift_q,     shift_d;
    logic [4:0]        bit_cnt_q,   bit_cnt_d;
    logic              busy_q,      busy_d;
    logic [N-1:0]      in_reg_q,    in_reg_d;
    logic              valid_q,     valid_d;
    logic [CODE_W-1:0] dac_a_q,     dac_a_d;
    logic [CODE_W-1:0] dac_b_q,     dac_b_d;
    logic              gain_a_q,    gain_a_d;
    logic              gain_b_q,    gain_b_d;
`ifdef SPI_DAC_RX_FRAME_CHECK_EN
    logic              err_q,       err_d;
`endif
    logic              w_commit;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        busy_d    = busy_q;
        in_reg_d  = in_reg_q;
        valid_d   = 1'b0;
        dac_a_d   = dac_a_q;
        dac_b_d   = dac_b_q;
        gain_a_d  = gain_a_q;
        gain_b_d  = gain_b_q;
        w_commit  = 1'b0;
`ifdef SPI_DAC_RX_FRAME_CHECK_EN
        err_d     = 1'b0;
`endif

        case (state_q)
            // Level-based entry lets a new frame start as soon as sync is
            // seen low again, without waiting for a falling edge.
            ST_IDLE: begin
                if (!sync_lvl) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 5'd0;
                    busy_d    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (sclk_fall) begin
                    shift_d = {shift_q[N-2:0], din_lvl};
                    if (bit_cnt_q != C_CNT_MAX) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                if (sync_rise) begin
                    state_d = ST_COMMIT;
                    busy_d  = 1'b0;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (bit_cnt_q == C_FRAME_LEN) begin
                    w_commit = 1'b1;
                end
`ifdef SPI_DAC_RX_FRAME_CHECK_EN
                else begin
                    err_d = 1'b1;
                end
`else
                // Over-long frame: the shift register already holds the
                // last N bits received.
                else if (bit_cnt_q > C_FRAME_LEN) begin
                    w_commit = 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_commit) begin
            in_reg_d = shift_q;
            valid_d  = 1'b1;
        end

        // DAC transfer reads in_reg_d so a commit and an ldac edge in the
        // same cycle transfer the new frame. clr overrides ldac.
        if (!clr_lvl) begin
            dac_a_d  = '0;
            dac_b_d  = '0;
            gain_a_d = 1'b0;
            gain_b_d = 1'b0;
        end else if (ldac_fall) begin
            if (in_reg_d[CH_BIT]) begin
                dac_b_d  = in_reg_d[CODE_MSB:0];
                gain_b_d = in_reg_d[GAIN_BIT];
            end else begin
                dac_a_d  = in_reg_d[CODE_MSB:0];
                gain_a_d = in_reg_d[GAIN_BIT];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= 5'd0;
            busy_q    <= 1'b0;
            in_reg_q  <= '0;
            valid_q   <= 1'b0;
            dac_a_q   <= '0;
            dac_b_q   <= '0;
            gain_a_q  <= 1'b0;
            gain_b_q  <= 1'b0;
`ifdef SPI_DAC_RX_FRAME_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
            in_reg_q  <= in_reg_d;
            valid_q   <= valid_d;
            dac_a_q   <= dac_a_d;
            dac_b_q   <= dac_b_d;
            gain_a_q  <= gain_a_d;
            gain_b_q  <= gain_b_d;
`ifdef SPI_DAC_RX_FRAME_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    // The input register is exactly the last committed frame.
    assign frame_data  = in_reg_q;
    assign frame_valid = valid_q;
    assign busy        = busy_q;
    assign dac_a       = dac_a_q;
    assign dac_b       = dac_b_q;
    assign gain_a      = gain_a_q;
    assign gain_b      = gain_b_q;
`ifdef SPI_DAC_RX_FRAME_CHECK_EN
    assign frame_err   = err_q;
`else
    assign frame_err   = 1'b0;
`endif

endmodule
`default_nettype wire
